// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one i2c_master between N_REQ requesters,
// issuing one single-byte transaction per grant and returning data/status.
module i2c_req_arbiter #(
  parameter int N_REQ      = 4,
  parameter int CMD_HOLD   = 1200,
  parameter int TIMEOUT    = 50_000,
  parameter int GAP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   rnw,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [7:0]         resp_rdata,
  output logic               resp_nack,
  output logic               resp_timeout,
  output logic               busy,
  output logic               m_write,
  output logic               m_read,
  output logic [6:0]         m_addr,
  output logic [7:0]         m_data_wr,
  input  logic [7:0]         m_data_rd,
  input  logic               m_done,
  input  logic               m_ack_error
);

  localparam int MAX_HT = (CMD_HOLD > TIMEOUT) ? CMD_HOLD : TIMEOUT;
  localparam int MAX_C  = (MAX_HT > GAP_CYCLES) ? MAX_HT : GAP_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int IW     = $clog2(N_REQ);

  localparam logic [CW-1:0] HOLD_LAST = CW'(CMD_HOLD - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  // The IDLE cycle that precedes a grant completes the inter-transaction gap.
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) return v;
    else return v + CW'(1);
  endfunction

  // Returns {found, index}; lowest offset from p+1 (with wrap) wins.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW:0] res;
    int          idx;
    res = {(IW+1){1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(p) + k) % N_REQ;
      if (r[IW'(idx)]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [N_REQ-1:0] oh;
    oh = {N_REQ{1'b0}};
    oh[i] = 1'b1;
    return oh;
  endfunction

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s, tcnt_r, tcnt_s;
  logic [IW-1:0]    ptr_r, ptr_s;
  logic             rnw_r, rnw_s;
  logic [N_REQ-1:0] gnt_r, gnt_s, resp_valid_r, resp_valid_s;
  logic [7:0]       resp_rdata_r, resp_rdata_s;
  logic             resp_nack_r, resp_nack_s, resp_timeout_r, resp_timeout_s;
  logic             busy_r, busy_s;
  logic             m_write_r, m_write_s, m_read_r, m_read_s;
  logic [6:0]       m_addr_r, m_addr_s;
  logic [7:0]       m_data_wr_r, m_data_wr_s;
  logic             done_d1_r, done_d2_r, done_d3_r;
  logic             done_rise_s;
  logic [IW:0]      pick_s;
  logic [IW-1:0]    win_s;
  logic             found_s;

  assign pick_s      = rr_pick(req, ptr_r);
  assign win_s       = pick_s[IW-1:0];
  assign found_s     = pick_s[IW];
  assign done_rise_s = done_d2_r & ~done_d3_r;

  // Synchronise the master's done (SCL domain) and keep the edge-detect flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_d1_r <= 1'b0;
      done_d2_r <= 1'b0;
      done_d3_r <= 1'b0;
    end else begin
      done_d1_r <= m_done;
      done_d2_r <= done_d1_r;
      done_d3_r <= done_d2_r;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_s        = state_r;
    cnt_s          = sat_inc(cnt_r);
    tcnt_s         = tcnt_r;
    ptr_s          = ptr_r;
    rnw_s          = rnw_r;
    gnt_s          = gnt_r;
    resp_valid_s   = {N_REQ{1'b0}};
    resp_rdata_s   = resp_rdata_r;
    resp_nack_s    = resp_nack_r;
    resp_timeout_s = resp_timeout_r;
    m_write_s      = m_write_r;
    m_read_s       = m_read_r;
    m_addr_s       = m_addr_r;
    m_data_wr_s    = m_data_wr_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s  = {CW{1'b0}};
        tcnt_s = {CW{1'b0}};
        if (found_s) begin
          state_s     = ST_ISSUE;
          ptr_s       = win_s;
          rnw_s       = rnw[win_s];
          gnt_s       = onehot(win_s);
          m_addr_s    = req_addr[int'(win_s)*7 +: 7];
          m_data_wr_s = req_wdata[int'(win_s)*8 +: 8];
          m_write_s   = ~rnw[win_s];
          m_read_s    = rnw[win_s];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tcnt_s = sat_inc(tcnt_r);
        if (cnt_r >= HOLD_LAST) begin
          state_s   = ST_WAIT;
          m_write_s = 1'b0;
          m_read_s  = 1'b0;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        tcnt_s = sat_inc(tcnt_r);
        if (done_rise_s) begin
          state_s        = ST_RESP;
          resp_valid_s   = gnt_r;
          resp_nack_s    = m_ack_error;
          resp_timeout_s = 1'b0;
          if (rnw_r) resp_rdata_s = m_data_rd;
          else resp_rdata_s = resp_rdata_r;
        end else if (tcnt_r >= TO_LAST) begin
          state_s        = ST_RESP;
          resp_valid_s   = gnt_r;
          resp_nack_s    = 1'b0;
          resp_timeout_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_GAP;
        gnt_s   = {N_REQ{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
      ST_GAP: begin
        if (cnt_r >= GAP_LAST) state_s = ST_IDLE;
        else state_s = ST_GAP;
      end
      default: begin
        state_s   = ST_IDLE;
        gnt_s     = {N_REQ{1'b0}};
        m_write_s = 1'b0;
        m_read_s  = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CW{1'b0}};
      tcnt_r         <= {CW{1'b0}};
      ptr_r          <= IW'(N_REQ - 1);
      rnw_r          <= 1'b0;
      gnt_r          <= {N_REQ{1'b0}};
      resp_valid_r   <= {N_REQ{1'b0}};
      resp_rdata_r   <= 8'h00;
      resp_nack_r    <= 1'b0;
      resp_timeout_r <= 1'b0;
      busy_r         <= 1'b0;
      m_write_r      <= 1'b0;
      m_read_r       <= 1'b0;
      m_addr_r       <= 7'h00;
      m_data_wr_r    <= 8'h00;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      tcnt_r         <= tcnt_s;
      ptr_r          <= ptr_s;
      rnw_r          <= rnw_s;
      gnt_r          <= gnt_s;
      resp_valid_r   <= resp_valid_s;
      resp_rdata_r   <= resp_rdata_s;
      resp_nack_r    <= resp_nack_s;
      resp_timeout_r <= resp_timeout_s;
      busy_r         <= busy_s;
      m_write_r      <= m_write_s;
      m_read_r       <= m_read_s;
      m_addr_r       <= m_addr_s;
      m_data_wr_r    <= m_data_wr_s;
    end
  end

  assign gnt          = gnt_r;
  assign resp_valid   = resp_valid_r;
  assign resp_rdata   = resp_rdata_r;
  assign resp_nack    = resp_nack_r;
  assign resp_timeout = resp_timeout_r;
  assign busy         = busy_r;
  assign m_write      = m_write_r;
  assign m_read       = m_read_r;
  assign m_addr       = m_addr_r;
  assign m_data_wr    = m_data_wr_r;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed self-checking bench for i2c_req_arbiter; the bench plays the
// i2c_master side by driving m_done/m_data_rd/m_ack_error by hand.
module tb_i2c_req_arbiter;

  localparam int N_REQ = 4;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]   req, rnw;
  logic [7*N_REQ-1:0] req_addr;
  logic [8*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]   gnt, resp_valid;
  logic [7:0]         resp_rdata;
  logic               resp_nack, resp_timeout, busy;
  logic               m_write, m_read;
  logic [6:0]         m_addr;
  logic [7:0]         m_data_wr, m_data_rd;
  logic               m_done, m_ack_error;

  int errors = 0;
  int checks = 0;
  int n;
  logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  i2c_req_arbiter #(
    .N_REQ(N_REQ), .CMD_HOLD(1200), .TIMEOUT(2000), .GAP_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rnw(rnw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_nack(resp_nack), .resp_timeout(resp_timeout),
    .busy(busy), .m_write(m_write), .m_read(m_read), .m_addr(m_addr),
    .m_data_wr(m_data_wr), .m_data_rd(m_data_rd), .m_done(m_done),
    .m_ack_error(m_ack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts cycles until the command strobe drops, bounded.
  task automatic wait_cmd_low(output int cycles);
    cycles = 0;
    while ((m_write || m_read) && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; rnw = '0; req_addr = '0; req_wdata = '0;
    m_data_rd = 8'h00; m_done = 1'b0; m_ack_error = 1'b0;
    tick(3);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd", {m_write, m_read}, 2'b00);
    check("rst_resp", resp_valid, 4'b0000);
    rst = 1'b0;

    // Single write, req dropped while granted
    req_addr[6:0] = 7'h50; req_wdata[7:0] = 8'hA5; rnw[0] = 1'b0; req[0] = 1'b1;
    tick(1);
    check("wr_gnt", gnt, 4'b0001);
    check("wr_cmd", {m_write, m_read}, 2'b10);
    check("wr_addr", m_addr, 7'h50);
    check("wr_data", m_data_wr, 8'hA5);
    check("wr_busy", busy, 1'b1);
    req[0] = 1'b0;
    wait_cmd_low(n);
    check("wr_hold", n, 1200);
    m_data_rd = 8'h77; m_done = 1'b1;
    tick(2);
    check("wr_resp_early", resp_valid, 4'b0000);
    tick(1);
    check("wr_resp", resp_valid, 4'b0001);
    check("wr_status", {resp_nack, resp_timeout}, 2'b00);
    check("wr_rdata_kept", resp_rdata, 8'h00);
    tick(1);
    m_done = 1'b0;
    check("wr_resp_pulse", resp_valid, 4'b0000);
    check("wr_gnt_clr", gnt, 4'b0000);
    tick(20);
    check("wr_idle", busy, 1'b0);

    // Single read from requester 2
    req_addr[20:14] = 7'h3C; rnw[2] = 1'b1; req[2] = 1'b1;
    tick(1);
    check("rd_gnt", gnt, 4'b0100);
    check("rd_cmd", {m_write, m_read}, 2'b01);
    check("rd_addr", m_addr, 7'h3C);
    req[2] = 1'b0;
    wait_cmd_low(n);
    check("rd_hold", n, 1200);
    m_data_rd = 8'h96; m_done = 1'b1;
    tick(3);
    check("rd_resp", resp_valid, 4'b0100);
    check("rd_rdata", resp_rdata, 8'h96);
    check("rd_nack", resp_nack, 1'b0);
    tick(1);
    m_done = 1'b0;
    tick(20);

    // NACK on requester 3, then requester 1 served normally
    rnw = '0; req_addr[27:21] = 7'h11; req_addr[13:7] = 7'h22; req_wdata[15:8] = 8'h5A;
    req = 4'b1010;
    tick(1);
    check("nk_gnt", gnt, 4'b1000);
    check("nk_addr", m_addr, 7'h11);
    req[3] = 1'b0;
    wait_cmd_low(n);
    m_ack_error = 1'b1; m_done = 1'b1;
    tick(3);
    check("nk_resp", resp_valid, 4'b1000);
    check("nk_status", {resp_nack, resp_timeout}, 2'b10);
    tick(1);
    m_done = 1'b0; m_ack_error = 1'b0;
    tick(15);
    check("nk_gap", gnt, 4'b0000);
    tick(1);
    check("nk_next_gnt", gnt, 4'b0010);
    check("nk_next_addr", m_addr, 7'h22);
    check("nk_next_data", m_data_wr, 8'h5A);
    req[1] = 1'b0;
    wait_cmd_low(n);
    m_done = 1'b1;
    tick(3);
    check("nk_next_resp", resp_valid, 4'b0010);
    check("nk_next_nack", resp_nack, 1'b0);
    tick(1);
    m_done = 1'b0;
    tick(20);

    // Contention: all four requesting from reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      req_addr[i*7 +: 7] = 7'(7'h10 + i);
      req_wdata[i*8 +: 8] = 8'(8'h40 + i);
    end
    rnw = '0; req = 4'b1111;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      check("ct_gnt", gnt, exp_gnt[k]);
      check("ct_addr", m_addr, 32'h10 + (k % 4));
      if (k == 4) req = '0;
      wait_cmd_low(n);
      m_done = 1'b1;
      tick(3);
      check("ct_resp", resp_valid, exp_gnt[k]);
      tick(1);
      m_done = 1'b0;
      tick(15);
      check("ct_gap", gnt, 4'b0000);
      tick(1);
    end

    // Timeout: done never arrives
    req[0] = 1'b1;
    tick(1);
    check("to_gnt", gnt, 4'b0001);
    req[0] = 1'b0;
    tick(1999);
    check("to_early", resp_valid, 4'b0000);
    tick(1);
    check("to_resp", resp_valid, 4'b0001);
    check("to_status", {resp_nack, resp_timeout}, 2'b01);
    tick(15);
    check("to_gap_busy", busy, 1'b1);
    tick(1);
    check("to_idle", busy, 1'b0);

    // Reset during WAIT, then pointer must be back at N_REQ-1
    req_addr[20:14] = 7'h3C; rnw[2] = 1'b1; req = 4'b0100;
    tick(1);
    check("mr_gnt", gnt, 4'b0100);
    req = '0;
    wait_cmd_low(n);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mr_gnt_clr", gnt, 4'b0000);
    check("mr_cmd", {m_write, m_read}, 2'b00);
    check("mr_busy", busy, 1'b0);
    check("mr_resp", resp_valid, 4'b0000);
    rnw = '0; req = 4'b1010;
    tick(1);
    check("mr_ptr", gnt, 4'b0010);
    check("mr_no_resp", resp_valid, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares one i2c_master instance between N_REQ independent requesters using round-robin single-byte transactions.
- Latches the winning requester's command and drives the master's write/read/addr/data_wr inputs.
- Detects the master's done pulse (generated on the divided SCL clock) through a synchroniser, then returns read data and status to the granted requester.
- Sits between system-side clients (sensor pollers, config loaders) and i2c_master.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CMD_HOLD, 1200, clk cycles m_write/m_read is held high; must exceed one full SCL period at the slowest speed mode in use
- TIMEOUT, 50_000, clk cycles from command issue to done before the transaction is aborted
- GAP_CYCLES, 16, idle clk cycles after each transaction before the next grant

Ports:
- clk, input, 1, system clock; same clock that feeds i2c_master
- rst, input, 1, synchronous active-high reset
- req, input, N_REQ, per-requester level request; requester holds it until its resp_valid bit pulses
- rnw, input, N_REQ, per-requester 1=read, 0=write
- req_addr, input, 7*N_REQ, packed 7-bit slave addresses; requester i uses bits [7i+6:7i]
- req_wdata, input, 8*N_REQ, packed write bytes; requester i uses bits [8i+7:8i]
- gnt, output, N_REQ, one-hot grant; high from latch until response
- resp_valid, output, N_REQ, one-cycle pulse on the granted bit at completion
- resp_rdata, output, 8, read byte; valid with resp_valid
- resp_nack, output, 1, master reported ack_error; valid with resp_valid
- resp_timeout, output, 1, TIMEOUT expired; valid with resp_valid
- busy, output, 1, high in any state other than IDLE
- m_write, output, 1, to master write
- m_read, output, 1, to master read
- m_addr, output, 7, to master addr
- m_data_wr, output, 8, to master data_wr
- m_data_rd, input, 8, from master data_rd
- m_done, input, 1, from master done; treated as asynchronous
- m_ack_error, input, 1, from master ack_error; sampled only after synchronised done rise

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - All outputs 0, state IDLE.
  - Round-robin pointer = N_REQ-1, so requester 0 has highest priority first.
  - Synchroniser flops and all counters cleared.
  - Reset mid-transaction drops m_write/m_read immediately. No resp_valid is produced for the aborted transaction. The master is reset separately by the system.
- Synchroniser: m_done passes through 2 flops (d1, d2) plus an edge flop d3. done_rise = d2 & ~d3. m_ack_error and m_data_rd are captured in the same cycle done_rise is seen.
- State IDLE:
  - If any req bit is set, select the first set bit searching from pointer+1 upward with wrap.
  - Latch rnw, addr and wdata of the winner into m_addr/m_data_wr and an internal rnw flop.
  - Set gnt one-hot, update pointer to the winner, go to ISSUE. Grant appears one cycle after req is sampled.
- State ISSUE:
  - m_write = ~rnw_q, m_read = rnw_q, held exactly CMD_HOLD cycles.
  - Then deassert both and go to WAIT.
  - m_read is dropped before the master reaches its read-ack state, so the master ends with STOP and does not continue a multi-byte read.
  - Timeout counter starts at entry to ISSUE.
- State WAIT:
  - On done_rise: capture m_data_rd into resp_rdata (reads only; writes leave resp_rdata unchanged), set resp_nack = m_ack_error, resp_timeout = 0, go to RESP.
  - If the timeout counter reaches TIMEOUT-1 first: resp_nack = 0, resp_timeout = 1, go to RESP.
  - done_rise in the same cycle as the timeout: done wins.
  - done_rise during ISSUE is ignored, because done is high only at the end of a transaction. A done level already high on entry does not count; only a rise counts.
- State RESP: pulse resp_valid[granted] for 1 cycle, clear gnt, go to GAP.
- State GAP:
  - Count GAP_CYCLES, then go to IDLE.
  - This guarantees the master has returned to its IDLE state and done has fallen before the next command.
- Requester rules:
  - Deasserting req while granted does not cancel; the transaction completes and resp_valid still pulses.
  - A req that is still high after its resp_valid is treated as a new request and arbitrated normally.
  - gnt is never multi-hot.
- Counter width is $clog2(max(CMD_HOLD, TIMEOUT, GAP_CYCLES)+1). Counters saturate rather than wrap.

Test Plan:
- Single write: req[0]=1, rnw=0, addr=0x50, wdata=0xA5, slave ACKs → gnt=0001, m_write high for 1200 cycles, m_addr=0x50, m_data_wr=0xA5; resp_valid[0] pulses with resp_nack=0, resp_timeout=0.
- Single read: req[2] read from 0x3C, slave returns 0x96 → m_read high for exactly 1200 cycles, master issues STOP after one byte, resp_rdata=0x96, resp_valid=0100.
- Contention: req=1111 held continuously after reset → grant order 0,1,2,3,0; each grant starts GAP_CYCLES+1 cycles after the previous resp_valid.
- NACK: slave absent at addr 0x11 → resp_nack=1, resp_timeout=0, resp_valid pulses, the next requester is then served normally.
- Timeout: m_done tied low, TIMEOUT=2000 → resp_valid pulses 2000 cycles after ISSUE entry with resp_timeout=1, busy low after GAP.
- Reset mid-op: assert rst for 1 cycle during WAIT → next edge: gnt=0, m_read=m_write=0, busy=0, no resp_valid; req[1] afterwards wins first (pointer reset).
